// File: rtl/vad_gate_ctrl_if.sv
// rtl/vad_gate_ctrl_if.sv - buffer-side and output-stream signals of the VAD gate controller
interface vad_gate_ctrl_if;
  logic        buf_wr_en;
  logic        buf_rd_en;
  logic [15:0] buf_data_in;
  logic [15:0] buf_data_out;
  logic        buf_full;
  logic        buf_empty;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  // Controller side: drives the buffer enables and the downstream stream.
  modport master (
    output buf_wr_en, buf_rd_en, buf_data_in, out_data, out_valid,
    input  buf_data_out, buf_full, buf_empty, out_ready
  );

  // Environment side: the circular buffer plus the downstream consumer.
  modport slave (
    input  buf_wr_en, buf_rd_en, buf_data_in, out_data, out_valid,
    output buf_data_out, buf_full, buf_empty, out_ready
  );
endinterface

// File: rtl/vad_gate_ctrl.sv
// rtl/vad_gate_ctrl.sv - pre-roll / active / hangover / flush sequencer for the VAD-gated sample FIFO
module vad_gate_ctrl #(
  parameter int BUFFER_SIZE = 24000,
  parameter int PREROLL     = 4000,
  parameter int HANGOVER    = 8000,
  parameter int CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        sample_in,
  input  logic               sample_valid,
  input  logic               vad_active,
  vad_gate_ctrl_if.master    bus,
  output logic               seg_start,
  output logic               seg_end,
  output logic               busy,
  output logic               overflow,
  output logic [CNT_W-1:0]   level
);

  localparam int HC_W = $clog2(HANGOVER + 1);
  localparam logic [CNT_W-1:0] LVL_FULL = CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] LVL_PRE  = CNT_W'(PREROLL);
  localparam logic [CNT_W-1:0] LVL_ONE  = CNT_W'(1);
  localparam logic [HC_W-1:0]  HC_LOAD  = HC_W'(HANGOVER);
  localparam logic [HC_W-1:0]  HC_ONE   = HC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HANGOVER,
    S_FLUSH
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [HC_W-1:0]  hang_cnt;
  logic [CNT_W-1:0] level_nxt;
  logic             wr_en;
  logic             rd_en;
  logic             drain_valid;
  logic             at_full;

  // The buffer full flag should agree with the shadow level; either one blocks a write.
  assign at_full = (level == LVL_FULL) || bus.buf_full;

  assign bus.buf_wr_en   = wr_en;
  assign bus.buf_rd_en   = rd_en;
  assign bus.buf_data_in = sample_in;
  assign bus.out_data    = bus.buf_data_out;
  assign bus.out_valid   = drain_valid;
  assign busy            = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Buffer enables and stream valid; in IDLE a write at the pre-roll depth also pops the oldest sample.
  always_comb begin
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    drain_valid = 1'b0;
    case (state)
      S_IDLE: begin
        wr_en = sample_valid;
        rd_en = sample_valid && (level == LVL_PRE);
      end
      S_ACTIVE, S_HANGOVER: begin
        drain_valid = !bus.buf_empty;
        rd_en       = drain_valid && bus.out_ready;
        wr_en       = sample_valid && !at_full;
      end
      S_FLUSH: begin
        drain_valid = !bus.buf_empty;
        rd_en       = drain_valid && bus.out_ready;
      end
      default: ;
    endcase
  end

  // Occupancy after this cycle's write/pop; a simultaneous write and pop cancel.
  always_comb begin
    level_nxt = level;
    if (wr_en && !rd_en)      level_nxt = level + LVL_ONE;
    else if (!wr_en && rd_en) level_nxt = level - LVL_ONE;
  end

  // Next-state selection; FLUSH closes as soon as the buffer will be empty after this cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (vad_active) state_nxt = S_ACTIVE;
      S_ACTIVE:   if (!vad_active) state_nxt = S_HANGOVER;
      S_HANGOVER: begin
        if (vad_active)                              state_nxt = S_ACTIVE;
        else if (sample_valid && hang_cnt == HC_ONE) state_nxt = S_FLUSH;
      end
      S_FLUSH:    if (level_nxt == '0) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Shadow level, hangover countdown, sticky overflow and segment boundary pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level     <= '0;
      hang_cnt  <= '0;
      overflow  <= 1'b0;
      seg_start <= 1'b0;
      seg_end   <= 1'b0;
    end else begin
      level     <= level_nxt;
      seg_start <= (state == S_IDLE)  && (state_nxt == S_ACTIVE);
      seg_end   <= (state == S_FLUSH) && (state_nxt == S_IDLE);
      if (state == S_ACTIVE && state_nxt == S_HANGOVER)
        hang_cnt <= HC_LOAD;
      else if (state == S_HANGOVER && !vad_active && sample_valid)
        hang_cnt <= hang_cnt - HC_ONE;
      if ((state == S_ACTIVE || state == S_HANGOVER) && sample_valid && at_full)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vad_gate_ctrl.sv
// tb/tb_vad_gate_ctrl.sv - directed scoreboard bench for vad_gate_ctrl with a behavioural circular buffer
module tb_vad_gate_ctrl;

  localparam int BS   = 16;
  localparam int PRE  = 4;
  localparam int HANG = 3;

  localparam int M_IDLE  = 0;
  localparam int M_ACT   = 1;
  localparam int M_HANG  = 2;
  localparam int M_FLUSH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        vad_active = 1'b0;
  logic        seg_start, seg_end, busy, overflow;
  logic [4:0]  level;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  int          m_state = M_IDLE;
  int          m_hc    = 0;
  logic        exp_ss  = 1'b0;
  logic        exp_se  = 1'b0;
  logic        exp_ovf = 1'b0;

  vad_gate_ctrl_if bus();

  vad_gate_ctrl #(.BUFFER_SIZE(BS), .PREROLL(PRE), .HANGOVER(HANG)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .vad_active   (vad_active),
    .bus          (bus),
    .seg_start    (seg_start),
    .seg_end      (seg_end),
    .busy         (busy),
    .overflow     (overflow),
    .level        (level)
  );

  always #5 clk = ~clk;

  // Behavioural circular buffer reset together with the controller.
  logic [15:0] mem [16];
  logic [3:0]  wp, rp;
  logic [4:0]  cnt;
  logic        fifo_w, fifo_r;

  assign bus.buf_data_out = mem[rp];
  assign bus.buf_full     = (cnt == 5'd16);
  assign bus.buf_empty    = (cnt == 5'd0);
  assign fifo_w = bus.buf_wr_en && !bus.buf_full  && !(bus.buf_rd_en && bus.buf_empty);
  assign fifo_r = bus.buf_rd_en && !bus.buf_empty && !(bus.buf_wr_en && bus.buf_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (fifo_w) wp <= wp + 4'd1;
      if (fifo_r) rp <= rp + 4'd1;
      if (fifo_w && !fifo_r) cnt <= cnt + 5'd1;
      else if (!fifo_w && fifo_r) cnt <= cnt - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_w) mem[wp] <= bus.buf_data_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: combinational outputs checked mid-cycle, model advanced, registers checked after the edge.
  task automatic step(input logic sv, input logic [15:0] d, input logic vad, input logic rdy);
    int lvl;
    logic [15:0] head;
    sample_valid  = sv;
    sample_in     = d;
    vad_active    = vad;
    bus.out_ready = rdy;
    @(negedge clk);
    lvl = exp_q.size();
    exp_ss = 1'b0;
    exp_se = 1'b0;
    if (m_state == M_IDLE) begin
      chk("idle_out_valid", bus.out_valid, 0);
      chk("idle_wr_en", bus.buf_wr_en, sv);
      chk("idle_rd_en", bus.buf_rd_en, sv && (lvl == PRE));
    end else begin
      chk("out_valid", bus.out_valid, lvl > 0);
      chk("rd_en", bus.buf_rd_en, (lvl > 0) && rdy);
      chk("wr_en", bus.buf_wr_en, (m_state != M_FLUSH) && sv && (lvl < BS));
      if (lvl > 0) begin
        head = exp_q[0];
        chk("out_data", bus.out_data, head);
        if (rdy) void'(exp_q.pop_front());
      end
    end
    if (sv) chk("buf_data_in", bus.buf_data_in, d);
    case (m_state)
      M_IDLE: begin
        if (sv) begin
          exp_q.push_back(d);
          if (lvl == PRE) void'(exp_q.pop_front());
        end
        if (vad) begin
          m_state = M_ACT;
          exp_ss  = 1'b1;
        end
      end
      M_ACT, M_HANG: begin
        if (sv) begin
          if (lvl < BS) exp_q.push_back(d);
          else          exp_ovf = 1'b1;
        end
        if (m_state == M_ACT) begin
          if (!vad) begin
            m_state = M_HANG;
            m_hc    = HANG;
          end
        end else if (vad) begin
          m_state = M_ACT;
        end else if (sv) begin
          m_hc--;
          if (m_hc == 0) m_state = M_FLUSH;
        end
      end
      default: begin
        if (exp_q.size() == 0) begin
          m_state = M_IDLE;
          exp_se  = 1'b1;
        end
      end
    endcase
    @(posedge clk);
    #1;
    chk("seg_start", seg_start, exp_ss);
    chk("seg_end", seg_end, exp_se);
    chk("busy", busy, m_state != M_IDLE);
    chk("level", level, exp_q.size());
    chk("overflow", overflow, exp_ovf);
  endtask

  initial begin
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seg_start", seg_start, 0);
    chk("rst_seg_end", seg_end, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_wr_en", bus.buf_wr_en, 0);
    chk("rst_rd_en", bus.buf_rd_en, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    rst = 1'b0;

    // Pre-roll: ten idle samples leave the last four buffered
    for (int i = 1; i <= 10; i++) step(1'b1, 16'(i), 1'b0, 1'b1);
    chk("preroll_level", level, PRE);
    step(1'b0, 16'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 16'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'(101 + i), 1'b1, 1'b1);

    // Hangover retrigger
    step(1'b1, 16'd200, 1'b0, 1'b1);
    step(1'b1, 16'd201, 1'b0, 1'b1);
    step(1'b1, 16'd202, 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b1, 1'b1);
    chk("retrigger_busy", busy, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'(210 + i), 1'b1, 1'b1);

    // Flush with backpressure
    step(1'b0, 16'd0, 1'b0, 1'b0);
    step(1'b1, 16'd300, 1'b0, 1'b0);
    step(1'b1, 16'd301, 1'b0, 1'b0);
    step(1'b1, 16'd302, 1'b0, 1'b0);
    for (int k = 0; k < 40 && m_state != M_IDLE; k++)
      step(1'b1, 16'(400 + k), 1'b0, (k % 2) == 0);
    chk("flush_done_busy", busy, 0);
    chk("flush_done_level", level, 0);

    // Overflow with the consumer stalled
    step(1'b0, 16'd0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 16'(500 + i), 1'b1, 1'b0);
    chk("ovf_level", level, BS);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 16; i++) step(1'b0, 16'd0, 1'b1, 1'b1);
    chk("ovf_drained", level, 0);

    // Reset in the middle of an active segment
    for (int i = 0; i < 9; i++) step(1'b1, 16'(600 + i), 1'b1, 1'b0);
    chk("pre_reset_level", level, 9);
    sample_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_level", level, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_seg_end", seg_end, 0);
    exp_q.delete();
    m_state = M_IDLE;
    exp_ovf = 1'b0;
    rst = 1'b0;

    // Onset on the same cycle as a sample arriving at the pre-roll depth
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(700 + i), 1'b0, 1'b0);
    step(1'b1, 16'd705, 1'b1, 1'b0);
    chk("simul_level", level, PRE);
    chk("simul_busy", busy, 1);
    for (int i = 0; i < 5; i++) step(1'b0, 16'd0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
